// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - md_unit opcodes, FSM state type and default latencies; DIV state only with MD_DIV_EN
package md_pkg;

   localparam int MD_MUL_LAT_DEF = 5;
   localparam int MD_DIV_LAT_DEF = 10;
   localparam int MD_CNT_W       = 8;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

`ifdef MD_DIV_EN
   typedef enum logic [1:0] {IDLE, MUL, DIV} md_state_t;
`else
   typedef enum logic [1:0] {IDLE, MUL} md_state_t;
`endif

endpackage

// File: rtl/md_div.sv
// rtl/md_div.sv - combinational signed/unsigned 32-bit divider (quotient toward zero, remainder takes dividend sign)
module md_div (
   input  logic        sgn,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] q,
   output logic [31:0] r
);

   logic        neg_a;
   logic        neg_b;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] uq;
   logic [31:0] ur;

   // Divide magnitudes, then restore signs; 0x80000000 / -1 wraps to 0x80000000 naturally.
   always_comb begin
      neg_a = sgn & a[31];
      neg_b = sgn & b[31];
      mag_a = neg_a ? (32'd0 - a) : a;
      mag_b = neg_b ? (32'd0 - b) : b;
      uq    = '0;
      ur    = '0;
      if (mag_b != 32'd0) begin
         uq = mag_a / mag_b;
         ur = mag_a % mag_b;
      end
      q = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
      r = neg_a ? (32'd0 - ur) : ur;
   end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle HI/LO multiply/divide unit; divider present only with MD_DIV_EN
module md_unit
   import md_pkg::*;
#(
   parameter int MUL_LAT = MD_MUL_LAT_DEF
`ifdef MD_DIV_EN
   ,
   parameter int DIV_LAT = MD_DIV_LAT_DEF
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        flush,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_t           state;
   md_state_t           state_n;
   logic [MD_CNT_W-1:0] cnt;
   logic [MD_CNT_W-1:0] cnt_n;
   logic                busy_n;
   logic [31:0]         hi_n;
   logic [31:0]         lo_n;
   logic [31:0]         op_a;
   logic [31:0]         op_a_n;
   logic [31:0]         op_b;
   logic [31:0]         op_b_n;
   logic                op_sgn;
   logic                op_sgn_n;
   logic [63:0]         ext_a;
   logic [63:0]         ext_b;
   logic [63:0]         prod;

   // Low 64 bits of a 64x64 product of extended operands give both signed and unsigned results.
   assign ext_a = {{32{op_sgn & op_a[31]}}, op_a};
   assign ext_b = {{32{op_sgn & op_b[31]}}, op_b};
   assign prod  = ext_a * ext_b;

`ifdef MD_DIV_EN
   logic [31:0] quo;
   logic [31:0] rem;

   md_div u_div (
      .sgn (op_sgn),
      .a   (op_a),
      .b   (op_b),
      .q   (quo),
      .r   (rem)
   );
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         busy   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         op_a   <= '0;
         op_b   <= '0;
         op_sgn <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         busy   <= busy_n;
         hi     <= hi_n;
         lo     <= lo_n;
         op_a   <= op_a_n;
         op_b   <= op_b_n;
         op_sgn <= op_sgn_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      busy_n   = busy;
      hi_n     = hi;
      lo_n     = lo;
      op_a_n   = op_a;
      op_b_n   = op_b;
      op_sgn_n = op_sgn;
      case (state)
         IDLE: begin
            if (start && !flush) begin
               case (md_op)
                  OP_MULT, OP_MULTU: begin
                     state_n  = MUL;
                     cnt_n    = MD_CNT_W'(MUL_LAT - 1);
                     busy_n   = 1'b1;
                     op_a_n   = A;
                     op_b_n   = B;
                     op_sgn_n = (md_op == OP_MULT);
                  end
`ifdef MD_DIV_EN
                  OP_DIV, OP_DIVU: begin
                     state_n  = DIV;
                     cnt_n    = MD_CNT_W'(DIV_LAT - 1);
                     busy_n   = 1'b1;
                     op_a_n   = A;
                     op_b_n   = B;
                     op_sgn_n = (md_op == OP_DIV);
                  end
`endif
                  OP_MTHI: hi_n = A;
                  OP_MTLO: lo_n = A;
                  default: ;
               endcase
            end
         end
         MUL: begin
            if (flush) begin
               state_n = IDLE;
               cnt_n   = '0;
               busy_n  = 1'b0;
            end else if (cnt == '0) begin
               state_n = IDLE;
               busy_n  = 1'b0;
               hi_n    = prod[63:32];
               lo_n    = prod[31:0];
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
`ifdef MD_DIV_EN
         DIV: begin
            if (flush) begin
               state_n = IDLE;
               cnt_n   = '0;
               busy_n  = 1'b0;
            end else if (cnt == '0) begin
               state_n = IDLE;
               busy_n  = 1'b0;
               // A zero divisor burns the full latency but leaves HI/LO alone.
               if (op_b != 32'd0) begin
                  hi_n = rem;
                  lo_n = quo;
               end
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
`endif
         default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit, follows MD_DIV_EN of the build
module tb_md_unit;

   localparam int MUL_LAT = 5;
   localparam int DIV_LAT = 10;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          nbusy;
      string       tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  md_op = 3'd0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int          total = 0;
   int          bad = 0;
   int          busy_cnt = 0;
   logic        obs_req = 1'b0;
   exp_t        sb_q[$];
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   bit          div_en;

   always #5 clk = ~clk;

`ifdef MD_DIV_EN
   md_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
`else
   md_unit #(.MUL_LAT(MUL_LAT)) dut (
`endif
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .md_op (md_op),
      .A     (A),
      .B     (B),
      .flush (flush),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic on the architectural HI/LO pair.
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int nb);
      longint          sa, sb, q, r;
      longint unsigned ua, ub, uq, ur;
      logic [63:0]     p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      nb = 0;
      case (op)
         3'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; nb = MUL_LAT; end
         3'd1: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; nb = MUL_LAT; end
         3'd2: if (div_en) begin
            nb = DIV_LAT;
            if (b != 32'd0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
         end
         3'd3: if (div_en) begin
            nb = DIV_LAT;
            if (b != 32'd0) begin uq = ua / ub; ur = ua % ub; m_lo = uq[31:0]; m_hi = ur[31:0]; end
         end
         3'd4: m_hi = a;
         3'd5: m_lo = a;
         default: ;
      endcase
   endtask

   task automatic post_obs(input logic [31:0] eh, input logic [31:0] el, input int nb, input string tag);
      exp_t e;
      e.hi = eh; e.lo = el; e.nbusy = nb; e.tag = tag;
      sb_q.push_back(e);
      obs_req = 1'b1;
   endtask

   task automatic wait_obs();
      int n = 0;
      while (obs_req && n < 20) begin @(negedge clk); n++; end
      if (obs_req) begin
         total++; bad++;
         $display("FAIL obs_timeout got=pending exp=consumed");
         obs_req = 1'b0;
      end
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
      if (busy !== 1'b0) begin
         total++; bad++;
         $display("FAIL %s.idle_timeout got=%b exp=0", tag, busy);
      end
   endtask

   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
      int nb;
      model(op, a, b, nb);
      @(negedge clk);
      start = 1'b1; md_op = op; A = a; B = b;
      @(negedge clk);
      start = 1'b0; md_op = 3'($urandom); A = $urandom; B = $urandom;
      wait_idle(tag);
      post_obs(m_hi, m_lo, nb, tag);
      wait_obs();
   endtask

   // Monitor: counts busy cycles per window and settles one expectation per request.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (obs_req) begin
            if (sb_q.size() == 0) begin
               total++; bad++;
               $display("FAIL sb_empty got=0 exp=1");
            end else begin
               e = sb_q.pop_front();
               chk({e.tag, ".hi"}, hi, e.hi);
               chk({e.tag, ".lo"}, lo, e.lo);
               chk({e.tag, ".busy_cycles"}, 32'(busy_cnt), 32'(e.nbusy));
            end
            busy_cnt = 0;
            obs_req  = 1'b0;
         end
         if (busy === 1'b1) busy_cnt++;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int          nb;
      logic [2:0]  rop;
      logic [31:0] ra, rb;
`ifdef MD_DIV_EN
      div_en = 1'b1;
`else
      div_en = 1'b0;
`endif
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      post_obs(32'd0, 32'd0, 0, "reset");
      wait_obs();

      do_op(3'd0, 32'hFFFFFFFE, 32'd3, "mult_neg");
      do_op(3'd1, 32'hFFFFFFFF, 32'd2, "multu");
      do_op(3'd2, 32'hFFFFFFF9, 32'd2, "div_m7_2");
      do_op(3'd3, 32'h12345678, 32'd0, "divu_by0");
      do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
      do_op(3'd3, 32'hFFFFFFFF, 32'd10, "divu");
      do_op(3'd4, 32'h00001234, 32'd0, "mthi");
      do_op(3'd5, 32'h0000ABCD, 32'd0, "mtlo");
      do_op(3'd6, 32'h11111111, 32'd5, "rsvd6");
      do_op(3'd7, 32'h22222222, 32'd5, "rsvd7");

      // MTLO while busy is ignored
      model(3'd0, 32'h00000123, 32'hFFFFFF00, nb);
      @(negedge clk); start = 1'b1; md_op = 3'd0; A = 32'h00000123; B = 32'hFFFFFF00;
      @(negedge clk); start = 1'b0;
      @(negedge clk); start = 1'b1; md_op = 3'd5; A = 32'hDEADBEEF;
      @(negedge clk); start = 1'b0;
      wait_idle("mtlo_busy");
      post_obs(m_hi, m_lo, nb, "mtlo_busy");
      wait_obs();

      // Flush on busy cycle 3, then a back-to-back start
      @(negedge clk); start = 1'b1; md_op = 3'd1; A = 32'hCAFEF00D; B = 32'h00000077;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      post_obs(m_hi, m_lo, 3, "flush_mul");
      model(3'd0, 32'h00012345, 32'h00000777, nb);
      start = 1'b1; md_op = 3'd0; A = 32'h00012345; B = 32'h00000777;
      @(negedge clk); start = 1'b0;
      wait_idle("b2b");
      post_obs(m_hi, m_lo, nb, "b2b");
      wait_obs();

      // Flush in IDLE blocks acceptance
      @(negedge clk); flush = 1'b1; start = 1'b1; md_op = 3'd4; A = 32'h55AA55AA;
      @(negedge clk); flush = 1'b0; start = 1'b0;
      post_obs(m_hi, m_lo, 0, "flush_idle");
      wait_obs();

      // Asynchronous reset on busy cycle 4, start on the first cycle after release
      rop = div_en ? 3'd2 : 3'd0;
      @(negedge clk); start = 1'b1; md_op = rop; A = 32'd1000; B = 32'd7;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid.busy", {31'd0, busy}, 32'd0);
      chk("rst_mid.hi", hi, 32'd0);
      chk("rst_mid.lo", lo, 32'd0);
      m_hi = '0; m_lo = '0;
      @(negedge clk); rst_n = 1'b1;
      post_obs(32'd0, 32'd0, 4, "rst_mid");
      model(3'd1, 32'h00000F0F, 32'h00000003, nb);
      start = 1'b1; md_op = 3'd1; A = 32'h00000F0F; B = 32'h00000003;
      @(negedge clk); start = 1'b0;
      wait_idle("post_rst");
      post_obs(m_hi, m_lo, nb, "post_rst");
      wait_obs();

      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         case ($urandom_range(0, 3))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 20));
            2: rb = 32'd0 - 32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         do_op(rop, ra, rb, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter MUL_LAT, default 5: busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_LAT, default 10: busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  system clock, all state rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  md_op valid this cycle.
REQ-006 SHALL have port md_op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved.
REQ-007 SHALL have port A  input  32  rs operand (dividend, multiplicand, MTHI/MTLO data).
REQ-008 SHALL have port B  input  32  rt operand (divisor, multiplier).
REQ-009 SHALL have port flush  input  1  exception/flush, aborts an in-flight operation.
REQ-010 SHALL have port busy  output  1  registered; high while an operation is in flight.
REQ-011 SHALL have port hi  output  32  HI register.
REQ-012 SHALL have port lo  output  32  LO register.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV with a down-counter cnt.
REQ-014 SHALL accept start only in IDLE with flush low; start while busy SHALL be ignored, with no state change.
REQ-015 MULT/MULTU accepted: operands latched; next state MUL; cnt=MUL_LAT-1; busy high from the next cycle for exactly MUL_LAT cycles.
REQ-016 DIV/DIVU accepted: next state DIV; cnt=DIV_LAT-1; busy high for exactly DIV_LAT cycles.
REQ-017 Each busy cycle SHALL decrement cnt; when cnt==0, the edge SHALL write hi/lo, return to IDLE and drop busy.
REQ-018 MULT: {hi,lo} = signed 64-bit A*B. MULTU: unsigned 64-bit product.
REQ-019 DIV: lo = signed quotient truncated toward zero, hi = remainder with the dividend's sign. DIVU: unsigned quotient and remainder.
REQ-020 Division with B==0 SHALL leave hi and lo unchanged but still occupy DIV_LAT busy cycles.
REQ-021 DIV with A=32'h80000000 and B=32'hFFFFFFFF SHALL give lo=32'h80000000, hi=0.
REQ-022 MTHI/MTLO accepted in IDLE SHALL write A to hi or lo at that edge, with zero latency and busy staying low.
REQ-023 Reserved md_op with start SHALL be a no-op.
REQ-024 flush high in MUL or DIV SHALL return the FSM to IDLE at the next edge with hi/lo unchanged and busy low.
REQ-025 flush high in IDLE SHALL block acceptance of start that cycle.
REQ-026 hi/lo SHALL hold their value except at the writes defined in REQ-017 and REQ-022.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, cnt=0, busy=0, hi=0, lo=0 and the latched operands to 0.
REQ-028 Reset asserted mid-operation SHALL discard the operation; the first cycle after release SHALL be able to accept start.

Configuration
REQ-029 With MD_DIV_EN defined: the divider, DIV state and DIV_LAT SHALL be present.
REQ-030 Without MD_DIV_EN: DIV/DIVU SHALL be treated as reserved no-ops, the DIV state SHALL not exist and busy SHALL never assert for them.

Structure
REQ-031 Package md_pkg SHALL hold the md_op encodings, the FSM state typedef and the default latency constants.
REQ-032 Sub-module md_div SHALL compute signed/unsigned quotient and remainder combinationally from the latched operands, instantiated only under MD_DIV_EN.
REQ-033 The multiply SHALL stay inline in md_unit.

Verification
REQ-034 MULT A=32'hFFFFFFFE, B=3 -> busy high 5 cycles, then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
REQ-035 MULTU A=32'hFFFFFFFF, B=2 -> hi=1, lo=32'hFFFFFFFE after 5 busy cycles.
REQ-036 DIV A=-7, B=2 -> after 10 busy cycles lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. Second DIVU B=0 -> hi/lo unchanged.
REQ-037 MTHI A=32'h1234 in IDLE -> hi=32'h1234 next cycle, busy stays 0. MTLO issued while busy -> ignored.
REQ-038 MULT started, then flush on busy cycle 3 -> busy low next cycle, hi/lo keep their prior values. Back-to-back start immediately accepted.
REQ-039 rst_n pulsed low on DIV busy cycle 4 -> busy, hi, lo = 0 immediately. Build without MD_DIV_EN: DIV -> busy never asserts.
